// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_flags_if #(
    parameter int W = 8,
    parameter int D = 32
);
    localparam int CW = $clog2(D + 1);

    logic          w_en;
    logic [W-1:0]  d_in;
    logic          r_en;
    logic [W-1:0]  d_out;
    logic          d_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output w_en, d_in, r_en,
        input  d_out, d_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, d_in, r_en,
        output d_out, d_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int W     = 8,
    parameter int D     = 32,
    parameter int AF_TH = 28,
    parameter int AE_TH = 4,
    parameter int FWFT  = 0
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_flags_if.slave bus
);
    localparam int CW = $clog2(D + 1);
    localparam int PW = $clog2(D);

    typedef logic [PW-1:0] ptr_t;

    logic [W-1:0]  mem [D];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          full_c;
    logic          empty_c;
    logic          wr_ok;
    logic          rd_ok;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(D - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full_c  = (count_q == CW'(D));
    assign empty_c = (count_q == '0);
    assign wr_ok   = bus.w_en && !full_c;
    assign rd_ok   = bus.r_en && !empty_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= bus.w_en && full_c;
            underflow_q <= bus.r_en && empty_c;
        end
    end

    // NOTE: the storage array carries no reset so it maps onto plain RAM;
    // the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr] <= bus.d_in;
    end

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CW'(AF_TH));
    assign bus.almost_empty = (count_q <= CW'(AE_TH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always on display; a read simply moves past it.
            assign bus.d_out   = mem[rd_ptr];
            assign bus.d_valid = !empty_c;
        end else begin : g_std
            logic [W-1:0] d_out_q;
            logic         d_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    d_out_q   <= '0;
                    d_valid_q <= 1'b0;
                end else begin
                    d_valid_q <= rd_ok;
                    if (rd_ok) d_out_q <= mem[rd_ptr];
                end
            end

            assign bus.d_out   = d_out_q;
            assign bus.d_valid = d_valid_q;
        end
    endgenerate
endmodule
